// File: rtl/cstn_rx.sv
// CSTN dual-scan panel bus receiver: oversamples XCK/LP/FLM/UD/LD on clk and
// rebuilds 48-bit packed pixel words with line/frame position tags and sticky errors.
`timescale 1ns/1ps
module cstn_rx #(
   parameter int WORDS_PER_LINE = 80,
   parameter int LINES          = 240,
   parameter int X_W            = 7,
   parameter int Y_W            = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           cstn_xck,
   input  logic           cstn_lp,
   input  logic           cstn_flm,
   input  logic [7:0]     cstn_ud,
   input  logic [7:0]     cstn_ld,
   output logic [47:0]    out_data,
   output logic [X_W-1:0] out_x,
   output logic [Y_W-1:0] out_y,
   output logic           out_sof,
   output logic           out_valid,
   input  logic           out_ready,
   input  logic           err_clr,
   output logic           err_ovf,
   output logic           err_partial,
   output logic           err_len
);
   localparam logic [X_W-1:0] X_FULL = X_W'(WORDS_PER_LINE);
   localparam logic [Y_W-1:0] Y_LAST = Y_W'(LINES - 1);

   logic [18:0]    sync1_q, sync2_q;
   logic           xck3_q, lp3_q;
   logic [1:0]     b_q, b_d;
   logic [15:0]    up_q, up_d, lo_q, lo_d;
   logic [X_W-1:0] x_q, x_d, px_q, px_d, ox_q, ox_d;
   logic [Y_W-1:0] y_q, y_d, py_q, py_d, oy_q, oy_d;
   logic           open_q, open_d, frame_q, frame_d;
   logic           pend_q, pend_d, psof_q, psof_d;
   logic [47:0]    pdata_q, pdata_d, odata_q, odata_d;
   logic           osof_q, osof_d, ovalid_q, ovalid_d;
   logic           ovf_q, ovf_d, part_q, part_d, len_q, len_d;
   logic           ovf_ev, part_ev, len_ev;

   logic           s_xck, s_lp, s_flm, xck_rise, lp_rise;
   logic [7:0]     s_ud, s_ld;

   assign {s_xck, s_lp, s_flm, s_ud, s_ld} = sync2_q;
   assign xck_rise = s_xck & ~xck3_q;
   assign lp_rise  = s_lp & ~lp3_q;

   // Upper/lower pixel i occupy adjacent 3-bit fields, upper first.
   function automatic logic [47:0] pack_word(input logic [23:0] up, input logic [23:0] lo);
      logic [47:0] w;
      w = '0;
      for (int i = 0; i < 8; i++) begin
         w[47-6*i -: 3] = up[23-3*i -: 3];
         w[44-6*i -: 3] = lo[23-3*i -: 3];
      end
      return w;
   endfunction

   always_comb begin
      b_d      = b_q;
      up_d     = up_q;
      lo_d     = lo_q;
      x_d      = x_q;
      y_d      = y_q;
      open_d   = open_q;
      frame_d  = frame_q;
      pend_d   = 1'b0;
      pdata_d  = pdata_q;
      px_d     = px_q;
      py_d     = py_q;
      psof_d   = psof_q;
      odata_d  = odata_q;
      ox_d     = ox_q;
      oy_d     = oy_q;
      osof_d   = osof_q;
      ovalid_d = ovalid_q;
      ovf_ev   = 1'b0;
      part_ev  = 1'b0;
      len_ev   = 1'b0;

      if (xck_rise) begin
         if (!open_q) begin
            open_d = 1'b1;
            if (s_flm) begin
               if (frame_q && (y_q != Y_LAST)) len_ev = 1'b1;
               frame_d = 1'b1;
               y_d     = '0;
            end else begin
               y_d = y_q + 1'b1;
            end
         end
         case (b_q)
            2'd0: begin
               up_d[15:8] = s_ud;
               lo_d[15:8] = s_ld;
               b_d        = 2'd1;
            end
            2'd1: begin
               up_d[7:0] = s_ud;
               lo_d[7:0] = s_ld;
               b_d       = 2'd2;
            end
            default: begin
               b_d     = 2'd0;
               pend_d  = 1'b1;
               pdata_d = pack_word({up_q, s_ud}, {lo_q, s_ld});
               px_d    = x_q;
               py_d    = y_d;
               psof_d  = (x_q == '0) && (y_d == '0);
               x_d     = x_q + 1'b1;
            end
         endcase
      end

      // LP is applied after the beat so a word completing on the same clock survives.
      if (lp_rise) begin
         if (b_d != 2'd0) part_ev = 1'b1;
         if (x_d != X_FULL) len_ev = 1'b1;
         b_d    = 2'd0;
         x_d    = '0;
         open_d = 1'b0;
      end

      if (pend_q) begin
         if (!ovalid_q || out_ready) begin
            odata_d  = pdata_q;
            ox_d     = px_q;
            oy_d     = py_q;
            osof_d   = psof_q;
            ovalid_d = 1'b1;
         end else begin
            ovf_ev = 1'b1;
         end
      end else if (ovalid_q && out_ready) begin
         ovalid_d = 1'b0;
      end

      ovf_d  = (ovf_q  & ~err_clr) | ovf_ev;
      part_d = (part_q & ~err_clr) | part_ev;
      len_d  = (len_q  & ~err_clr) | len_ev;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q  <= '0;
         sync2_q  <= '0;
         xck3_q   <= 1'b0;
         lp3_q    <= 1'b0;
         b_q      <= '0;
         up_q     <= '0;
         lo_q     <= '0;
         x_q      <= '0;
         y_q      <= '0;
         open_q   <= 1'b0;
         frame_q  <= 1'b0;
         pend_q   <= 1'b0;
         pdata_q  <= '0;
         px_q     <= '0;
         py_q     <= '0;
         psof_q   <= 1'b0;
         odata_q  <= '0;
         ox_q     <= '0;
         oy_q     <= '0;
         osof_q   <= 1'b0;
         ovalid_q <= 1'b0;
         ovf_q    <= 1'b0;
         part_q   <= 1'b0;
         len_q    <= 1'b0;
      end else begin
         sync1_q  <= {cstn_xck, cstn_lp, cstn_flm, cstn_ud, cstn_ld};
         sync2_q  <= sync1_q;
         xck3_q   <= s_xck;
         lp3_q    <= s_lp;
         b_q      <= b_d;
         up_q     <= up_d;
         lo_q     <= lo_d;
         x_q      <= x_d;
         y_q      <= y_d;
         open_q   <= open_d;
         frame_q  <= frame_d;
         pend_q   <= pend_d;
         pdata_q  <= pdata_d;
         px_q     <= px_d;
         py_q     <= py_d;
         psof_q   <= psof_d;
         odata_q  <= odata_d;
         ox_q     <= ox_d;
         oy_q     <= oy_d;
         osof_q   <= osof_d;
         ovalid_q <= ovalid_d;
         ovf_q    <= ovf_d;
         part_q   <= part_d;
         len_q    <= len_d;
      end
   end

   assign out_data    = odata_q;
   assign out_x       = ox_q;
   assign out_y       = oy_q;
   assign out_sof     = osof_q;
   assign out_valid   = ovalid_q;
   assign err_ovf     = ovf_q;
   assign err_partial = part_q;
   assign err_len     = len_q;
endmodule

// File: tb/tb_cstn_rx.sv
// Self-checking bench for cstn_rx: panel-level stimulus against a beat/line reference model.
`timescale 1ns/1ps
module tb_cstn_rx;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic        xck = 1'b0, lp = 1'b0, flm = 1'b0;
   logic [7:0]  ud = '0, ld = '0;
   logic        out_ready = 1'b1, err_clr = 1'b0;
   logic [47:0] out_data;
   logic [6:0]  out_x;
   logic [7:0]  out_y;
   logic        out_sof, out_valid, err_ovf, err_partial, err_len;
   logic [47:0] f_data;
   logic [6:0]  f_x;
   logic [7:0]  f_y;
   logic        f_sof, f_valid, f_ovf, f_partial, f_len;

   always #5 clk = ~clk;

   cstn_rx dut (
      .clk(clk), .rst_n(rst_n), .cstn_xck(xck), .cstn_lp(lp), .cstn_flm(flm),
      .cstn_ud(ud), .cstn_ld(ld), .out_data(out_data), .out_x(out_x), .out_y(out_y),
      .out_sof(out_sof), .out_valid(out_valid), .out_ready(out_ready), .err_clr(err_clr),
      .err_ovf(err_ovf), .err_partial(err_partial), .err_len(err_len));

   // One word per line so full 240-line frames stay short.
   cstn_rx #(.WORDS_PER_LINE(1)) dut_f (
      .clk(clk), .rst_n(rst_n), .cstn_xck(xck), .cstn_lp(lp), .cstn_flm(flm),
      .cstn_ud(ud), .cstn_ld(ld), .out_data(f_data), .out_x(f_x), .out_y(f_y),
      .out_sof(f_sof), .out_valid(f_valid), .out_ready(1'b1), .err_clr(err_clr),
      .err_ovf(f_ovf), .err_partial(f_partial), .err_len(f_len));

   typedef struct packed {
      logic [47:0] d;
      logic [6:0]  x;
      logic [7:0]  y;
      logic        sof;
   } word_t;

   word_t expq[$];
   int    vectors = 0, miscompares = 0;

   int         m_beats, m_x, m_y, m_stall;
   logic [23:0] m_up, m_lo;
   bit         m_open, m_frame, m_part, m_len, m_lenf, m_ovf;

   function automatic logic [47:0] interleave(input logic [23:0] u, input logic [23:0] l);
      logic [47:0] r;
      r = '0;
      for (int i = 0; i < 8; i++)
         r = (r << 6) | 48'(((u >> (21 - 3*i)) & 24'h7) << 3) | 48'((l >> (21 - 3*i)) & 24'h7);
      return r;
   endfunction

   task automatic tick;
      @(posedge clk);
      #2;
   endtask

   task automatic model_reset;
      m_beats = 0; m_x = 0; m_y = 0; m_stall = 0;
      m_up = '0; m_lo = '0;
      m_open = 0; m_frame = 0; m_part = 0; m_len = 0; m_lenf = 0; m_ovf = 0;
      expq.delete();
   endtask

   task automatic model_lp;
      if (m_beats != 0) begin
         m_part  = 1;
         m_beats = 0;
      end
      if (m_x != 80) m_len = 1;
      if (m_x != 1) m_lenf = 1;
      m_x    = 0;
      m_open = 0;
   endtask

   task automatic send_beat(input logic [7:0] u, input logic [7:0] l, input bit with_lp);
      word_t w;
      ud = u; ld = l;
      tick; tick;
      xck = 1'b1;
      if (with_lp) lp = 1'b1;
      tick; tick;
      xck = 1'b0;
      lp  = 1'b0;
      if (!m_open) begin
         m_open = 1;
         if (flm) begin
            if (m_frame && m_y != 239) begin m_len = 1; m_lenf = 1; end
            m_frame = 1;
            m_y     = 0;
         end else begin
            m_y = (m_y + 1) % 256;
         end
      end
      m_up = {m_up[15:0], u};
      m_lo = {m_lo[15:0], l};
      m_beats++;
      if (m_beats == 3) begin
         m_beats = 0;
         w.d   = interleave(m_up, m_lo);
         w.x   = 7'(m_x % 128);
         w.y   = 8'(m_y);
         w.sof = (m_x == 0) && (m_y == 0);
         if (!out_ready && m_stall > 0) m_ovf = 1;
         else begin
            expq.push_back(w);
            if (!out_ready) m_stall++;
         end
         m_x++;
      end
      if (with_lp) begin
         repeat (4) tick;
         model_lp();
      end
   endtask

   task automatic send_lp;
      lp = 1'b1;
      tick; tick;
      lp = 1'b0;
      repeat (4) tick;
      model_lp();
   endtask

   task automatic set_ready(input logic r);
      out_ready = r;
      if (r) m_stall = 0;
   endtask

   task automatic clear_err;
      err_clr = 1'b1;
      tick;
      err_clr = 1'b0;
      m_ovf = 0; m_part = 0; m_len = 0; m_lenf = 0;
   endtask

   task automatic chk_flags(input string tag);
      repeat (6) tick;
      vectors++;
      assert ({err_ovf, err_partial, err_len} === {m_ovf, m_part, m_len})
      else begin
         miscompares++;
         $error("FAIL %s flags ovf/partial/len got=%b%b%b exp=%b%b%b", tag,
                err_ovf, err_partial, err_len, m_ovf, m_part, m_len);
      end
   endtask

   task automatic chk_frame_len(input string tag);
      repeat (6) tick;
      vectors++;
      assert (f_len === m_lenf)
      else begin
         miscompares++;
         $error("FAIL %s frame err_len got=%b exp=%b", tag, f_len, m_lenf);
      end
   endtask

   task automatic drain(input string tag);
      repeat (20) tick;
      vectors++;
      assert (expq.size() === 0)
      else begin
         miscompares++;
         $error("FAIL %s drain words_pending got=%0d exp=0", tag, expq.size());
      end
   endtask

   task automatic reset_dut(input string tag);
      rst_n = 1'b0;
      xck = 1'b0; lp = 1'b0; flm = 1'b0;
      tick; tick;
      vectors++;
      assert ({out_data, out_x, out_y, out_sof, out_valid, err_ovf, err_partial, err_len} === 68'd0)
      else begin
         miscompares++;
         $error("FAIL %s reset_outputs got=%h/%0d/%0d/%b/%b/%b%b%b exp=all zero", tag,
                out_data, out_x, out_y, out_sof, out_valid, err_ovf, err_partial, err_len);
      end
      model_reset();
      rst_n = 1'b1;
      tick;
   endtask

   task automatic send_words(input int n);
      for (int w = 0; w < n; w++)
         for (int b = 0; b < 3; b++) send_beat(8'($urandom), 8'($urandom), 1'b0);
   endtask

   // Scoreboard: every accepted word, and every held word, is checked against the model queue.
   always @(negedge clk) begin
      if (rst_n && out_valid) begin
         if (expq.size() == 0) begin
            vectors++;
            assert (out_valid === 1'b0)
            else begin
               miscompares++;
               $error("FAIL unexpected_word got=%h x=%0d y=%0d exp=no word", out_data, out_x, out_y);
            end
         end else begin
            vectors++;
            assert ({out_data, out_x, out_y, out_sof} === expq[0])
            else begin
               miscompares++;
               $error("FAIL word got=%h x=%0d y=%0d sof=%b exp=%h x=%0d y=%0d sof=%b",
                      out_data, out_x, out_y, out_sof, expq[0].d, expq[0].x, expq[0].y, expq[0].sof);
            end
            if (out_ready) void'(expq.pop_front());
         end
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      reset_dut("por");

      // First word with known pattern, held while not ready, then rest of an 80-word line.
      set_ready(1'b0);
      flm = 1'b1;
      send_beat(8'hA5, 8'h5A, 1'b0);
      send_beat(8'h0F, 8'hF0, 1'b0);
      send_beat(8'h3C, 8'hC3, 1'b0);
      flm = 1'b0;
      repeat (4) tick;
      vectors++;
      assert ({out_data, out_x, out_y, out_sof, out_valid} === {48'hA8E547E23E23, 7'd0, 8'd0, 1'b1, 1'b1})
      else begin
         miscompares++;
         $error("FAIL first_word got=%h x=%0d y=%0d sof=%b v=%b exp=a8e547e23e23 x=0 y=0 sof=1 v=1",
                out_data, out_x, out_y, out_sof, out_valid);
      end
      set_ready(1'b1);
      send_words(79);
      send_lp();
      chk_flags("line80");
      drain("line80");

      // Last beat of the line lands on the same clock as LP.
      for (int w = 0; w < 80; w++)
         for (int b = 0; b < 3; b++)
            send_beat(8'($urandom), 8'($urandom), (w == 79) && (b == 2));
      chk_flags("beat_with_lp");
      drain("beat_with_lp");

      // Overflow: second word arrives while first is still held.
      set_ready(1'b0);
      send_words(2);
      chk_flags("overflow");
      set_ready(1'b1);
      drain("overflow");
      clear_err();
      chk_flags("err_clr");

      // Partial word cut off by LP.
      reset_dut("partial");
      flm = 1'b1;
      send_beat(8'($urandom), 8'($urandom), 1'b0);
      send_beat(8'($urandom), 8'($urandom), 1'b0);
      flm = 1'b0;
      send_lp();
      chk_flags("partial");
      send_words(1);
      send_lp();
      chk_flags("after_partial");
      drain("after_partial");

      // Frame length: 240 lines wrap cleanly, 239 lines flag err_len.
      reset_dut("frame");
      for (int f = 0; f < 2; f++) begin
         for (int ln = 0; ln < 240 - f; ln++) begin
            flm = (ln == 0);
            send_words(1);
            flm = 1'b0;
            send_lp();
         end
         chk_frame_len("frame_body");
      end
      flm = 1'b1;
      send_words(1);
      flm = 1'b0;
      send_lp();
      chk_frame_len("short_frame");
      chk_flags("frame");
      drain("frame");

      // Randomized lines: random lengths, FLM and data.
      reset_dut("random");
      for (int ln = 0; ln < 12; ln++) begin
         flm = ($urandom_range(0, 3) == 0);
         for (int b = $urandom_range(0, 14); b > 0; b--) send_beat(8'($urandom), 8'($urandom), 1'b0);
         flm = 1'b0;
         send_lp();
         chk_flags("random");
      end
      drain("random");

      // Reset mid-word with a word held; no stale beats afterwards.
      set_ready(1'b0);
      send_words(1);
      send_beat(8'($urandom), 8'($urandom), 1'b0);
      set_ready(1'b1);
      reset_dut("midword");
      send_words(1);
      send_lp();
      chk_flags("midword");
      drain("midword");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
